matrix_memory: RTL and testbench

MATRIX_MEMORY -- requirements
Module: matrix_memory

---
 rtl/matrix_pkg.sv | 17 +
 rtl/clear_sequencer.sv | 59 +++++
 rtl/matrix_memory.sv | 99 +++++++++
 tb/tb_matrix_memory.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and default geometry for the matrix memory block.
package matrix_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int DEFAULT_ROWS  = 2;
    localparam int DEFAULT_COLS  = 2;
    localparam int DEFAULT_WIDTH = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clear_sequencer.sv
// Zeroing-sweep controller: walks ptr from 0 to DEPTH-1, one address per cycle.
module clear_sequencer
    import matrix_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Reset lands in CLEAR so the array is always swept before first use.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_o  = 1'b1;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
        endcase
    end

    assign ptr_o  = ptr_q;
    assign busy_o = (state_q == CLEAR);

endmodule

// File: rtl/matrix_memory.sv
// ROWS x COLS element store with registered reads, range checking and a
// self-timed zeroing sweep on reset or clear request.
module matrix_memory
    import matrix_pkg::*;
#(
    parameter  int ROWS   = DEFAULT_ROWS,
    parameter  int COLS   = DEFAULT_COLS,
    parameter  int WIDTH  = DEFAULT_WIDTH,
    localparam int DEPTH  = ROWS * COLS,
    localparam int IDX_W  = max2(1, $clog2(max2(ROWS, COLS))),
    localparam int ADDR_W = max2(1, $clog2(DEPTH))
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    output logic             busy_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_row_i,
    input  logic [IDX_W-1:0] wr_col_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_row_i,
    input  logic [IDX_W-1:0] rd_col_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             addr_err_o
);

    logic [ADDR_W-1:0] sweep_ptr;
    logic              busy;
    logic              sweep_done;

    clear_sequencer #(
        .DEPTH (DEPTH),
        .PTR_W (ADDR_W)
    ) u_clear_sequencer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (clear_i),
        .ptr_o   (sweep_ptr),
        .busy_o  (busy),
        .done_o  (sweep_done)
    );

    assign busy_o = busy;

    // The sweep may only finish as the last address is being zeroed.
    assert property (@(posedge clk_i) disable iff (rst_i)
        sweep_done |-> (busy && sweep_ptr == ADDR_W'(DEPTH - 1)));

    logic              wr_in_range, rd_in_range;
    logic              wr_ok, wr_oor, rd_ok, rd_oor;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign wr_in_range = (int'(wr_row_i) < ROWS) && (int'(wr_col_i) < COLS);
    assign rd_in_range = (int'(rd_row_i) < ROWS) && (int'(rd_col_i) < COLS);
    assign wr_addr     = ADDR_W'(int'(wr_row_i) * COLS + int'(wr_col_i));
    assign rd_addr     = ADDR_W'(int'(rd_row_i) * COLS + int'(rd_col_i));

    // A clear request in the same idle cycle takes priority over the write.
    assign wr_ok  = !busy && !rst_i && wr_en_i && wr_in_range && !clear_i;
    assign wr_oor = !busy && wr_en_i && !wr_in_range;
    assign rd_ok  = !busy && rd_en_i && rd_in_range;
    assign rd_oor = !busy && rd_en_i && !rd_in_range;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset branch; the sweep zeroes it so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (busy && !rst_i) begin
            mem_q[sweep_ptr] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data_i;
        end
    end

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, addr_err_q;

    // Sampling the array before this edge's write gives read-before-write.
    assign rd_data_d = rd_ok ? mem_q[rd_addr] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_ok;
            addr_err_q <= wr_oor || rd_oor;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_matrix_memory.sv
// Bench for matrix_memory: a default 2x2 instance and a 3x2 instance for range checks.
module tb_matrix_memory;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // 2x2 instance, IDX_W = 1
    logic       a_clear, a_busy, a_wr_en, a_rd_en, a_rd_valid, a_addr_err;
    logic [0:0] a_wr_row, a_wr_col, a_rd_row, a_rd_col;
    logic [7:0] a_wr_data, a_rd_data;

    // 3x2 instance, IDX_W = 2
    logic       b_clear, b_busy, b_wr_en, b_rd_en, b_rd_valid, b_addr_err;
    logic [1:0] b_wr_row, b_wr_col, b_rd_row, b_rd_col;
    logic [7:0] b_wr_data, b_rd_data;

    matrix_memory dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (a_clear),
        .busy_o     (a_busy),
        .wr_en_i    (a_wr_en),
        .wr_row_i   (a_wr_row),
        .wr_col_i   (a_wr_col),
        .wr_data_i  (a_wr_data),
        .rd_en_i    (a_rd_en),
        .rd_row_i   (a_rd_row),
        .rd_col_i   (a_rd_col),
        .rd_data_o  (a_rd_data),
        .rd_valid_o (a_rd_valid),
        .addr_err_o (a_addr_err)
    );

    matrix_memory #(.ROWS(3), .COLS(2), .WIDTH(8)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (b_clear),
        .busy_o     (b_busy),
        .wr_en_i    (b_wr_en),
        .wr_row_i   (b_wr_row),
        .wr_col_i   (b_wr_col),
        .wr_data_i  (b_wr_data),
        .rd_en_i    (b_rd_en),
        .rd_row_i   (b_rd_row),
        .rd_col_i   (b_rd_col),
        .rd_data_o  (b_rd_data),
        .rd_valid_o (b_rd_valid),
        .addr_err_o (b_addr_err)
    );

    // Reference contents, indexed row*COLS + col.
    logic [7:0] a_model [4];
    logic [7:0] b_model [6];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_clear = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        a_wr_row = '0; a_wr_col = '0; a_rd_row = '0; a_rd_col = '0; a_wr_data = '0;
    endtask

    task automatic b_idle();
        b_clear = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        b_wr_row = '0; b_wr_col = '0; b_rd_row = '0; b_rd_col = '0; b_wr_data = '0;
    endtask

    task automatic zero_models();
        for (int i = 0; i < 4; i++) a_model[i] = 8'h00;
        for (int i = 0; i < 6; i++) b_model[i] = 8'h00;
    endtask

    // Counts cycles with busy high from now until it drops (bounded).
    task automatic a_count_busy(output int n);
        n = 0;
        while (a_busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic a_readback(input string tag);
        for (int i = 0; i < 4; i++) begin
            a_idle();
            a_rd_en = 1'b1; a_rd_row = 1'(i / 2); a_rd_col = 1'(i % 2);
            tick();
            n_checks++;
            if ({a_rd_valid, a_rd_data} !== {1'b1, a_model[i]})
                $display("FAIL %s[%0d]: got valid=%0b data=%02h, want valid=1 data=%02h",
                         tag, i, a_rd_valid, a_rd_data, a_model[i]);
            else n_pass++;
        end
        a_idle();
    endtask

    task automatic test_reset();
        int n;
        a_idle(); b_idle();
        rst = 1'b1;
        a_rd_en = 1'b1;
        tick();
        n_checks++;
        if ({a_busy, a_rd_valid, a_rd_data, a_addr_err} !== {1'b1, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_state: got busy=%0b valid=%0b data=%02h err=%0b, want 1/0/00/0",
                     a_busy, a_rd_valid, a_rd_data, a_addr_err);
        else n_pass++;
        rst = 1'b0;
        a_idle();
        zero_models();
        a_count_busy(n);
        n_checks++;
        if (n != 4) $display("FAIL reset_sweep_len: got %0d busy cycles, want 4", n);
        else n_pass++;
        a_readback("reset_readback");
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b0, 8'h00})
            $display("FAIL no_read_zero: got valid=%0b data=%02h, want 0/00", a_rd_valid, a_rd_data);
        else n_pass++;
    endtask

    task automatic test_write_read();
        a_idle();
        a_wr_en = 1'b1; a_wr_row = 1'b1; a_wr_col = 1'b0; a_wr_data = 8'hA5;
        tick();
        a_model[2] = 8'hA5;
        a_idle();
        a_rd_en = 1'b1; a_rd_row = 1'b1; a_rd_col = 1'b0;
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 8'hA5})
            $display("FAIL write_read: got valid=%0b data=%02h, want 1/a5", a_rd_valid, a_rd_data);
        else n_pass++;
        a_idle();
        tick();
        n_checks++;
        if (a_rd_valid !== 1'b0)
            $display("FAIL valid_one_cycle: got valid=%0b, want 0", a_rd_valid);
        else n_pass++;
    endtask

    task automatic test_read_before_write();
        a_idle();
        a_wr_en = 1'b1; a_wr_row = 1'b0; a_wr_col = 1'b1; a_wr_data = 8'h11;
        tick();
        a_model[1] = 8'h11;
        a_wr_data = 8'h3C;
        a_rd_en = 1'b1; a_rd_row = 1'b0; a_rd_col = 1'b1;
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 8'h11})
            $display("FAIL rbw_old: got valid=%0b data=%02h, want 1/11", a_rd_valid, a_rd_data);
        else n_pass++;
        a_model[1] = 8'h3C;
        a_wr_en = 1'b0;
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 8'h3C})
            $display("FAIL rbw_new: got valid=%0b data=%02h, want 1/3c", a_rd_valid, a_rd_data);
        else n_pass++;
        a_idle();
    endtask

    task automatic test_random_a();
        for (int k = 0; k < 300; k++) begin
            int         r_w, c_w, r_r, c_r;
            logic [7:0] d, exp_d;
            logic       we, re;
            we = 1'($urandom_range(1, 0)); re = 1'($urandom_range(1, 0));
            r_w = $urandom_range(1, 0); c_w = $urandom_range(1, 0);
            r_r = $urandom_range(1, 0); c_r = $urandom_range(1, 0);
            d = 8'($urandom);
            a_wr_en = we; a_wr_row = 1'(r_w); a_wr_col = 1'(c_w); a_wr_data = d;
            a_rd_en = re; a_rd_row = 1'(r_r); a_rd_col = 1'(c_r);
            exp_d = re ? a_model[r_r * 2 + c_r] : 8'h00;
            if (we) a_model[r_w * 2 + c_w] = d;
            tick();
            n_checks++;
            if ({a_addr_err, a_rd_valid, a_rd_data} !== {1'b0, re, exp_d})
                $display("FAIL random_a[%0d]: got err=%0b valid=%0b data=%02h, want 0/%0b/%02h",
                         k, a_addr_err, a_rd_valid, a_rd_data, re, exp_d);
            else n_pass++;
        end
        a_idle();
    endtask

    task automatic test_clear_sweep();
        int n;
        a_idle();
        for (int i = 0; i < 4; i++) begin
            a_wr_en = 1'b1; a_wr_row = 1'(i / 2); a_wr_col = 1'(i % 2); a_wr_data = 8'hFF;
            tick();
            a_model[i] = 8'hFF;
        end
        a_idle();
        a_clear = 1'b1;
        a_wr_en = 1'b1; a_wr_row = 1'b0; a_wr_col = 1'b0; a_wr_data = 8'h55;
        tick();
        n = 0;
        while (a_busy === 1'b1 && n < 20) begin
            n++;
            a_clear = 1'($urandom_range(1, 0));
            a_wr_en = 1'b1; a_wr_row = 1'($urandom_range(1, 0));
            a_wr_col = 1'($urandom_range(1, 0)); a_wr_data = 8'($urandom);
            a_rd_en = 1'b1; a_rd_row = 1'($urandom_range(1, 0)); a_rd_col = 1'($urandom_range(1, 0));
            tick();
            n_checks++;
            if ({a_rd_valid, a_addr_err} !== 2'b00)
                $display("FAIL busy_ignores_access: got valid=%0b err=%0b, want 0/0",
                         a_rd_valid, a_addr_err);
            else n_pass++;
        end
        a_idle();
        n_checks++;
        if (n != 4) $display("FAIL clear_sweep_len: got %0d busy cycles, want 4", n);
        else n_pass++;
        zero_models();
        a_readback("clear_readback");
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        a_idle();
        a_clear = 1'b1;
        tick();
        a_idle();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_count_busy(n);
        n_checks++;
        if (n != 4) $display("FAIL rst_mid_sweep_len: got %0d busy cycles, want 4", n);
        else n_pass++;
        a_wr_en = 1'b1; a_wr_row = 1'b1; a_wr_col = 1'b1; a_wr_data = 8'h9E;
        tick();
        a_idle();
        a_rd_en = 1'b1; a_rd_row = 1'b1; a_rd_col = 1'b1;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_data} !== {1'b0, 8'h00})
            $display("FAIL rst_drops_read: got valid=%0b data=%02h, want 0/00", a_rd_valid, a_rd_data);
        else n_pass++;
        rst = 1'b0;
        a_idle();
        a_count_busy(n);
        n_checks++;
        if (n != 4) $display("FAIL rst_access_sweep_len: got %0d busy cycles, want 4", n);
        else n_pass++;
        zero_models();
        a_readback("rst_readback");
    endtask

    task automatic test_out_of_range();
        int m;
        b_idle();
        m = 0;
        while (b_busy === 1'b1 && m < 20) begin
            m++;
            tick();
        end
        n_checks++;
        if (b_busy !== 1'b0) $display("FAIL b_sweep_end: got busy=%0b, want 0", b_busy);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            b_wr_en = 1'b1; b_wr_row = 2'(i / 2); b_wr_col = 2'(i % 2);
            b_wr_data = 8'($urandom);
            b_model[i] = b_wr_data;
            tick();
        end
        b_idle();
        b_wr_en = 1'b1; b_wr_row = 2'd3; b_wr_col = 2'd0; b_wr_data = 8'h77;
        tick();
        n_checks++;
        if ({b_addr_err, b_rd_valid} !== 2'b10)
            $display("FAIL oor_row_write: got err=%0b valid=%0b, want 1/0", b_addr_err, b_rd_valid);
        else n_pass++;
        b_idle();
        tick();
        n_checks++;
        if (b_addr_err !== 1'b0) $display("FAIL err_one_cycle: got err=%0b, want 0", b_addr_err);
        else n_pass++;
        b_wr_en = 1'b1; b_wr_row = 2'd0; b_wr_col = 2'd3; b_wr_data = 8'h66;
        tick();
        n_checks++;
        if (b_addr_err !== 1'b1) $display("FAIL oor_col_write: got err=%0b, want 1", b_addr_err);
        else n_pass++;
        b_idle();
        b_rd_en = 1'b1; b_rd_row = 2'd3; b_rd_col = 2'd1;
        tick();
        n_checks++;
        if ({b_addr_err, b_rd_valid, b_rd_data} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL oor_read: got err=%0b valid=%0b data=%02h, want 1/0/00",
                     b_addr_err, b_rd_valid, b_rd_data);
        else n_pass++;
        b_rd_row = 2'd3; b_rd_col = 2'd0;
        b_wr_en = 1'b1; b_wr_row = 2'd2; b_wr_col = 2'd2; b_wr_data = 8'h44;
        tick();
        b_idle();
        n_checks++;
        if (b_addr_err !== 1'b1) $display("FAIL oor_both: got err=%0b, want 1", b_addr_err);
        else n_pass++;
        tick();
        n_checks++;
        if (b_addr_err !== 1'b0) $display("FAIL oor_both_single: got err=%0b, want 0", b_addr_err);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            b_rd_en = 1'b1; b_rd_row = 2'(i / 2); b_rd_col = 2'(i % 2);
            tick();
            n_checks++;
            if ({b_addr_err, b_rd_valid, b_rd_data} !== {1'b0, 1'b1, b_model[i]})
                $display("FAIL oor_readback[%0d]: got err=%0b valid=%0b data=%02h, want 0/1/%02h",
                         i, b_addr_err, b_rd_valid, b_rd_data, b_model[i]);
            else n_pass++;
        end
        b_idle();
    endtask

    task automatic test_random_b();
        for (int k = 0; k < 300; k++) begin
            int         r_w, c_w, r_r, c_r;
            logic [7:0] d, exp_d;
            logic       we, re, w_in, r_in, exp_v, exp_e;
            we = 1'($urandom_range(1, 0)); re = 1'($urandom_range(1, 0));
            r_w = $urandom_range(3, 0); c_w = $urandom_range(3, 0);
            r_r = $urandom_range(3, 0); c_r = $urandom_range(3, 0);
            d = 8'($urandom);
            b_wr_en = we; b_wr_row = 2'(r_w); b_wr_col = 2'(c_w); b_wr_data = d;
            b_rd_en = re; b_rd_row = 2'(r_r); b_rd_col = 2'(c_r);
            w_in  = (r_w < 3) && (c_w < 2);
            r_in  = (r_r < 3) && (c_r < 2);
            exp_v = re && r_in;
            exp_d = exp_v ? b_model[r_r * 2 + c_r] : 8'h00;
            exp_e = (we && !w_in) || (re && !r_in);
            if (we && w_in) b_model[r_w * 2 + c_w] = d;
            tick();
            n_checks++;
            if ({b_addr_err, b_rd_valid, b_rd_data} !== {exp_e, exp_v, exp_d})
                $display("FAIL random_b[%0d]: got err=%0b valid=%0b data=%02h, want %0b/%0b/%02h",
                         k, b_addr_err, b_rd_valid, b_rd_data, exp_e, exp_v, exp_d);
            else n_pass++;
        end
        b_idle();
    endtask

    initial begin
        a_idle();
        b_idle();
        tick();
        test_reset();
        test_write_read();
        test_read_before_write();
        test_random_a();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_out_of_range();
        test_random_b();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached without completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
